// File: rtl/hazard_pkg.sv
// hazard_pkg: opcodes, forwarding encodings and FSM states shared by the hazard unit
package hazard_pkg;
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;
    typedef enum logic [1:0] {RUN, LU_STALL, BR_FLUSH} state_t;
endpackage

// File: rtl/hazard_fwd_ctrl_if.sv
// hazard_fwd_ctrl_if: pipeline-side signals of the hazard/forwarding unit
interface hazard_fwd_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [31:0]      id_inst;
    logic             id_valid;
    logic             mux_sel_ctrl;
    logic             hold_in;
    logic [1:0]       fwd_ctrl_a;
    logic [1:0]       fwd_ctrl_b;
    logic             pc_write;
    logic             if_id_write;
    logic             id_ex_bubble;
    logic             if_id_flush;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
    modport master (
        output id_inst, id_valid, mux_sel_ctrl, hold_in,
        input  fwd_ctrl_a, fwd_ctrl_b, pc_write, if_id_write, id_ex_bubble, if_id_flush,
               stall_cnt, flush_cnt
    );
    modport slave (
        input  id_inst, id_valid, mux_sel_ctrl, hold_in,
        output fwd_ctrl_a, fwd_ctrl_b, pc_write, if_id_write, id_ex_bubble, if_id_flush,
               stall_cnt, flush_cnt
    );
endinterface

// File: rtl/inst_decode.sv
// inst_decode: extracts sources, destination and write/load/rt-read flags from an instruction
module inst_decode import hazard_pkg::*; #(
    parameter int REG_AW = 5
) (
    input  logic [31:0]       inst,
    output logic [REG_AW-1:0] rs,
    output logic [REG_AW-1:0] rt,
    output logic [REG_AW-1:0] dst,
    output logic              wr,
    output logic              ld,
    output logic              reads_rt
);
    logic [5:0] op;
    logic       writes;
    logic       unused_bits;
    assign op = inst[31:26];
    assign rs = inst[25 -: REG_AW];
    assign rt = inst[20 -: REG_AW];
    assign unused_bits = ^inst[10:0];
    // Classify the opcode; a write to register 0 is never treated as a producer
    always_comb begin
        dst      = op == OP_RTYPE ? inst[15 -: REG_AW] : rt;
        writes   = op inside {OP_RTYPE, OP_LW, OP_ADDI, OP_ANDI, OP_ORI};
        wr       = writes && dst != '0;
        ld       = op == OP_LW && wr;
        reads_rt = op inside {OP_RTYPE, OP_SW, OP_BEQ};
    end
endmodule

// File: rtl/hazard_fwd_ctrl.sv
// hazard_fwd_ctrl: load-use stall, branch flush and EX/MEM, MEM/WB forwarding control
module hazard_fwd_ctrl import hazard_pkg::*; #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input logic              clk,
    input logic              rst_n,
    hazard_fwd_ctrl_if.slave bus
);
    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] dst;
        logic              wr;
        logic              ld;
    } slot_t;
    slot_t             ex, mem, wb, id_slot;
    state_t            state, state_nxt;
    logic [REG_AW-1:0] rs, rt, dst;
    logic              wr, ld, reads_rt, lu, br, hold, bubble, unused_bits;
    logic [1:0]        fa, fb, fa_nxt, fb_nxt;
    logic [CNT_W-1:0]  stall_cnt, flush_cnt;

    inst_decode #(.REG_AW(REG_AW)) u_dec (
        .inst(bus.id_inst), .rs(rs), .rt(rt), .dst(dst), .wr(wr), .ld(ld), .reads_rt(reads_rt)
    );

    // Hazard detection, operand source selection and FSM next state
    always_comb begin
        hold      = bus.hold_in;
        br        = bus.mux_sel_ctrl;
        id_slot   = {bus.id_valid, dst, wr, ld};
        lu        = bus.id_valid && ex.valid && ex.ld && (rs == ex.dst || (reads_rt && rt == ex.dst));
        bubble    = br || lu || !bus.id_valid;
        fa_nxt    = ex.valid && ex.wr && rs == ex.dst ? FWD_EXMEM :
                    mem.valid && mem.wr && rs == mem.dst ? FWD_MEMWB : FWD_RF;
        fb_nxt    = !reads_rt ? FWD_RF :
                    ex.valid && ex.wr && rt == ex.dst ? FWD_EXMEM :
                    mem.valid && mem.wr && rt == mem.dst ? FWD_MEMWB : FWD_RF;
        state_nxt = hold ? state : br ? BR_FLUSH : lu ? LU_STALL : RUN;
    end

    assign bus.pc_write     = !rst_n || (!hold && (br || !lu));
    assign bus.if_id_write  = !rst_n || (!hold && (br || !lu));
    assign bus.id_ex_bubble = rst_n && !hold && (br || lu);
    assign bus.if_id_flush  = rst_n && !hold && br;
    assign bus.fwd_ctrl_a   = fa;
    assign bus.fwd_ctrl_b   = fb;
    assign bus.stall_cnt    = stall_cnt;
    assign bus.flush_cnt    = flush_cnt;
    assign unused_bits      = ^{wb, mem.ld};

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= RUN;
        else        state <= state_nxt;
    end

    // Shadow pipeline slots, registered forwarding selects and saturating event counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex        <= '0;
            mem       <= '0;
            wb        <= '0;
            fa        <= FWD_RF;
            fb        <= FWD_RF;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (!hold) begin
            ex  <= bubble ? '0 : id_slot;
            mem <= ex;
            wb  <= mem;
            fa  <= bubble ? FWD_RF : fa_nxt;
            fb  <= bubble ? FWD_RF : fb_nxt;
            if (lu && !br && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
            if (br && flush_cnt != '1) flush_cnt <= flush_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// tb_hazard_fwd_ctrl: directed scoreboard bench for the hazard/forwarding unit
module tb_hazard_fwd_ctrl;
    import hazard_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    hazard_fwd_ctrl_if #(.CNT_W(16)) bus ();
    hazard_fwd_ctrl_if #(.CNT_W(2))  bus2 ();

    hazard_fwd_ctrl #(.REG_AW(5), .CNT_W(16)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
    hazard_fwd_ctrl #(.REG_AW(5), .CNT_W(2))  dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

    int          n_cmp = 0;
    int          n_err = 0;
    logic [35:0] exp_q[$];
    string       tag_q[$];

    function automatic logic [31:0] rtype(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
        return {OP_RTYPE, rs, rt, rd, 11'h020};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rt, input logic [4:0] rs);
        return {op, rs, rt, 16'h0004};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // drive one ID-stage cycle, check same-cycle controls, then check registered results after the edge
    task automatic step(input string tag, input logic [31:0] inst, input logic v, input logic br,
                        input logic hold, input logic pcw, input logic bub, input logic fl,
                        input logic [1:0] fa, input logic [1:0] fb, input logic [15:0] sc,
                        input logic [15:0] fc);
        logic [35:0] e;
        string       t;
        bus.id_inst      = inst;
        bus.id_valid     = v;
        bus.mux_sel_ctrl = br;
        bus.hold_in      = hold;
        #1;
        chk({tag, ".pc_write"}, 32'(bus.pc_write), 32'(pcw));
        chk({tag, ".if_id_write"}, 32'(bus.if_id_write), 32'(pcw));
        chk({tag, ".id_ex_bubble"}, 32'(bus.id_ex_bubble), 32'(bub));
        chk({tag, ".if_id_flush"}, 32'(bus.if_id_flush), 32'(fl));
        exp_q.push_back({fa, fb, sc, fc});
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        chk({t, ".fwd_a"}, 32'(bus.fwd_ctrl_a), 32'(e[35:34]));
        chk({t, ".fwd_b"}, 32'(bus.fwd_ctrl_b), 32'(e[33:32]));
        chk({t, ".stall_cnt"}, 32'(bus.stall_cnt), 32'(e[31:16]));
        chk({t, ".flush_cnt"}, 32'(bus.flush_cnt), 32'(e[15:0]));
    endtask

    initial begin
        bus.id_inst = '0;  bus.id_valid = 1'b0;  bus.mux_sel_ctrl = 1'b1; bus.hold_in = 1'b0;
        bus2.id_inst = '0; bus2.id_valid = 1'b0; bus2.mux_sel_ctrl = 1'b0; bus2.hold_in = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("rst.pc_write", 32'(bus.pc_write), 32'd1);
        chk("rst.if_id_write", 32'(bus.if_id_write), 32'd1);
        chk("rst.id_ex_bubble", 32'(bus.id_ex_bubble), 32'd0);
        chk("rst.if_id_flush", 32'(bus.if_id_flush), 32'd0);
        chk("rst.fwd_a", 32'(bus.fwd_ctrl_a), 32'd0);
        chk("rst.fwd_b", 32'(bus.fwd_ctrl_b), 32'd0);
        chk("rst.stall_cnt", 32'(bus.stall_cnt), 32'd0);
        chk("rst.flush_cnt", 32'(bus.flush_cnt), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        // EX/MEM forwarding on operand A
        step("add3",      rtype(3, 1, 2), 1, 0, 0, 1, 0, 0, 2'b00, 2'b00, 0, 0);
        step("sub_dep",   rtype(4, 3, 5), 1, 0, 0, 1, 0, 0, 2'b01, 2'b00, 0, 0);
        // MEM/WB forwarding across a bubble, then newest producer wins
        step("add3b",     rtype(3, 1, 2), 1, 0, 0, 1, 0, 0, 2'b00, 2'b00, 0, 0);
        step("nop",       32'h0,          0, 0, 0, 1, 0, 0, 2'b00, 2'b00, 0, 0);
        step("or_mem",    rtype(6, 7, 3), 1, 0, 0, 1, 0, 0, 2'b00, 2'b10, 0, 0);
        step("add3c",     rtype(3, 1, 2), 1, 0, 0, 1, 0, 0, 2'b00, 2'b00, 0, 0);
        step("add3d",     rtype(3, 4, 5), 1, 0, 0, 1, 0, 0, 2'b00, 2'b00, 0, 0);
        step("or_both",   rtype(6, 3, 3), 1, 0, 0, 1, 0, 0, 2'b01, 2'b01, 0, 0);
        // load-use stall, then the consumer forwards from MEM/WB
        step("lw8",       itype(OP_LW, 8, 1), 1, 0, 0, 1, 0, 0, 2'b00, 2'b00, 0, 0);
        step("lu_add",    rtype(9, 8, 2),     1, 0, 0, 0, 1, 0, 2'b00, 2'b00, 1, 0);
        step("lu_add_re", rtype(9, 8, 2),     1, 0, 0, 1, 0, 0, 2'b10, 2'b00, 1, 0);
        // branch concurrent with load-use: flush wins, no stall counted
        step("lw8b",      itype(OP_LW, 8, 1), 1, 0, 0, 1, 0, 0, 2'b00, 2'b00, 1, 0);
        step("br_lu",     rtype(9, 8, 2),     1, 1, 0, 1, 1, 1, 2'b00, 2'b00, 1, 1);
        step("nop2",      32'h0,              0, 0, 0, 1, 0, 0, 2'b00, 2'b00, 1, 1);
        // hold freezes everything, including over a branch, then forwarding resumes
        step("add3e",     rtype(3, 1, 2), 1, 0, 0, 1, 0, 0, 2'b00, 2'b00, 1, 1);
        step("sub_first", rtype(4, 3, 5), 1, 0, 0, 1, 0, 0, 2'b01, 2'b00, 1, 1);
        step("hold1",     rtype(7, 4, 4), 1, 0, 1, 0, 0, 0, 2'b01, 2'b00, 1, 1);
        step("hold2_br",  rtype(7, 4, 4), 1, 1, 1, 0, 0, 0, 2'b01, 2'b00, 1, 1);
        step("hold3",     rtype(7, 4, 4), 1, 0, 1, 0, 0, 0, 2'b01, 2'b00, 1, 1);
        step("resume",    rtype(7, 4, 4), 1, 0, 0, 1, 0, 0, 2'b01, 2'b01, 1, 1);
        // hold dominates a load-use stall
        step("lw8c",      itype(OP_LW, 8, 1), 1, 0, 0, 1, 0, 0, 2'b00, 2'b00, 1, 1);
        step("hold_lu",   rtype(9, 8, 2),     1, 0, 1, 0, 0, 0, 2'b00, 2'b00, 1, 1);
        step("lu_after",  rtype(9, 8, 2),     1, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2, 1);
        step("lu_re2",    rtype(9, 8, 2),     1, 0, 0, 1, 0, 0, 2'b10, 2'b00, 2, 1);
        // register 0 is never a producer, for ALU ops or loads
        step("add0",      rtype(0, 1, 2),     1, 0, 0, 1, 0, 0, 2'b00, 2'b00, 2, 1);
        step("use0",      rtype(4, 0, 0),     1, 0, 0, 1, 0, 0, 2'b00, 2'b00, 2, 1);
        step("lw0",       itype(OP_LW, 0, 1), 1, 0, 0, 1, 0, 0, 2'b00, 2'b00, 2, 1);
        step("use0_lw",   rtype(9, 0, 2),     1, 0, 0, 1, 0, 0, 2'b00, 2'b00, 2, 1);
        // reset while in LU_STALL with a pending MEM/WB forward and a branch
        step("lw8d",      itype(OP_LW, 8, 1), 1, 0, 0, 1, 0, 0, 2'b00, 2'b00, 2, 1);
        step("lu_pre",    rtype(9, 8, 2),     1, 0, 0, 0, 1, 0, 2'b00, 2'b00, 3, 1);
        bus.id_inst = rtype(9, 8, 2); bus.id_valid = 1'b1; bus.mux_sel_ctrl = 1'b1; bus.hold_in = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mid_rst.pc_write", 32'(bus.pc_write), 32'd1);
        chk("mid_rst.if_id_write", 32'(bus.if_id_write), 32'd1);
        chk("mid_rst.id_ex_bubble", 32'(bus.id_ex_bubble), 32'd0);
        chk("mid_rst.if_id_flush", 32'(bus.if_id_flush), 32'd0);
        chk("mid_rst.stall_cnt", 32'(bus.stall_cnt), 32'd0);
        chk("mid_rst.flush_cnt", 32'(bus.flush_cnt), 32'd0);
        @(posedge clk);
        #1;
        chk("mid_rst_edge.fwd_a", 32'(bus.fwd_ctrl_a), 32'd0);
        chk("mid_rst_edge.flush_cnt", 32'(bus.flush_cnt), 32'd0);
        rst_n = 1'b1;
        step("post_rst",  rtype(4, 8, 8), 1, 0, 0, 1, 0, 0, 2'b00, 2'b00, 0, 0);
        // narrow counters saturate at all-ones
        for (int i = 0; i < 4; i++) begin
            bus2.mux_sel_ctrl = 1'b1;
            @(posedge clk);
            #1;
            chk("sat_flush_cnt", 32'(bus2.flush_cnt), i < 3 ? 32'(i + 1) : 32'd3);
        end
        bus2.mux_sel_ctrl = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus2.id_inst  = itype(OP_LW, 8, 1);
            bus2.id_valid = 1'b1;
            @(posedge clk);
            #1 bus2.id_inst = rtype(9, 8, 2);
            #1;
            chk("sat_stall_pc_write", 32'(bus2.pc_write), 32'd0);
            @(posedge clk);
            #1;
            chk("sat_stall_cnt", 32'(bus2.stall_cnt), i < 3 ? 32'(i + 1) : 32'd3);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/hazard_fwd_ctrl.md
HAZARD_FWD_CTRL -- requirements
Module: hazard_fwd_ctrl

Interface
REQ-001 SHALL have parameter REG_AW, default 5, meaning register-index width.
REQ-002 SHALL have parameter CNT_W, default 16, meaning event-counter width.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 id_inst  input  32  instruction in ID (opcode [31:26], rs [25:21], rt [20:16], rd [15:11]).
REQ-006 id_valid  input  1  id_inst is a real instruction (0 = bubble).
REQ-007 mux_sel_ctrl  input  1  branch taken, resolved in EX this cycle.
REQ-008 hold_in  input  1  data-memory busy; freeze pipeline.
REQ-009 fwd_ctrl_a, fwd_ctrl_b  output  2 each  ALU operand-A/B source for instruction in EX, registered.
REQ-010 pc_write, if_id_write  output  1 each  PC / IF-ID register update enables.
REQ-011 id_ex_bubble  output  1  load ID/EX with NOP this cycle.
REQ-012 if_id_flush  output  1  clear IF/ID this cycle.
REQ-013 stall_cnt, flush_cnt  output  CNT_W each  saturating event counters.

Function
REQ-014 Decode: opcode 0 -> writes rd; 0x23 (lw) -> writes rt, load; 0x08/0x0C/0x0D (addi/andi/ori) -> writes rt; 0x2B (sw), 0x04 (beq) -> no write; all read rs; R-type, sw, beq also read rt.
REQ-015 Destination 0 SHALL never be marked as a producer.
REQ-016 Block SHALL track shadow slots EX, MEM, WB, each holding {valid, dst, wr, ld}; on a non-hold edge ID -> EX -> MEM -> WB shift, EX receiving the ID decode or a bubble.
REQ-017 Fwd encoding: 00 register file, 01 ex_dm_alu_out (EX/MEM), 10 dm_wb_mux_out (MEM/WB); 11 never driven.
REQ-018 fwd_ctrl_x SHALL be computed from the ID source vs. the EX slot (-> 01) and MEM slot (-> 10) and registered on the same edge the instruction enters EX (latency 1); EX-slot match has priority.
REQ-019 Load-use: EX slot valid, ld=1, dst equals an ID source actually read -> same cycle pc_write=0, if_id_write=0, id_ex_bubble=1; FSM RUN -> LU_STALL.
REQ-020 LU_STALL lasts exactly one cycle, then returns to RUN; hazard re-evaluated there (the bubble removes it).
REQ-021 Branch: mux_sel_ctrl=1 -> if_id_flush=1, id_ex_bubble=1, pc_write=1; FSM -> BR_FLUSH for one cycle, then RUN.
REQ-022 Branch and load-use in same cycle: branch wins; no stall, stall_cnt unchanged.
REQ-023 hold_in=1: pc_write=if_id_write=0, id_ex_bubble=if_id_flush=0, slots, fwd registers, FSM and counters unchanged; hold dominates branch and stall.
REQ-024 Bubble into EX SHALL yield EX slot valid=0 and registered fwd 00/00.
REQ-025 stall_cnt +1 per load-use stall cycle, flush_cnt +1 per branch flush; both saturate at all-ones, no wrap.
REQ-026 Outside hold/stall/flush: pc_write=if_id_write=1, id_ex_bubble=if_id_flush=0.

Reset
REQ-027 rst_n low SHALL immediately clear all slots, fwd_ctrl_a/b=00, counters=0, FSM=RUN; pc_write=if_id_write=1, other outputs 0.
REQ-028 Reset mid-stall or mid-flush SHALL abandon it; first post-reset cycle is RUN with empty slots.

Structure
REQ-029 Opcode constants, fwd encodings and FSM state enum SHALL live in shared package hazard_pkg.
REQ-030 Decode SHALL be one sub-module, inst_decode (inst -> rs, rt, dst, wr, ld, reads_rt).

Verification
REQ-031 add $3,$1,$2 then sub $4,$3,$5: second in EX sees fwd_ctrl_a=01, fwd_ctrl_b=00.
REQ-032 add $3; nop; or $6,$7,$3: or in EX sees fwd_ctrl_b=10; with add $3,..; add $3,..; or $6,$3,$3: both 01 (newest wins).
REQ-033 lw $8,0($1) then add $9,$8,$2: one cycle pc_write=0, id_ex_bubble=1, stall_cnt=1; add then gets fwd_ctrl_a=10.
REQ-034 mux_sel_ctrl=1 concurrent with load-use: if_id_flush=1, no stall, flush_cnt=1, stall_cnt=0.
REQ-035 hold_in=1 for 3 cycles during add->sub dependence: outputs frozen, then fwd_ctrl_a=01 resumes; writes to $0 never forward.
REQ-036 rst_n low mid-LU_STALL: immediate fwd 00, counters 0, pc_write=1; counter preset near max saturates at all-ones.
